// File: rtl/kbd_link_pkg.sv
// rtl/kbd_link_pkg.sv - Mac Plus keyboard link constants, FSM states and key-byte selection
package kbd_link_pkg;

    localparam logic [7:0] CMD_INQUIRY = 8'h10;
    localparam logic [7:0] CMD_INSTANT = 8'h14;
    localparam logic [7:0] CMD_MODEL   = 8'h16;
    localparam logic [7:0] CMD_TEST    = 8'h36;

    localparam logic [7:0] RSP_NULL    = 8'h7B;
    localparam logic [7:0] RSP_MODEL   = 8'h0B;
    localparam logic [7:0] RSP_ACK     = 8'h7D;
    localparam logic [7:0] PFX_KEYPAD  = 8'h79;
    localparam logic [7:0] PFX_SHIFT   = 8'h71;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD_LO,
        ST_CMD_HI,
        ST_DECODE,
        ST_INQ_WAIT,
        ST_RSP_PRE,
        ST_RSP_LO,
        ST_RSP_HI
    } link_state_t;

    typedef struct packed {
        logic [7:0] rsp;
        logic       pop;
        logic       prefix_next;
    } key_sel_t;

    // Extended keys go out as a prefix byte first; the key itself stays queued until the next poll.
    function automatic key_sel_t select_key(input logic       empty,
                                            input logic       prefix_pending,
                                            input logic [9:0] head);
        key_sel_t sel;
        sel.rsp         = RSP_NULL;
        sel.pop         = 1'b0;
        sel.prefix_next = prefix_pending;
        if (!empty) begin
            if (prefix_pending) begin
                sel.rsp         = head[7:0];
                sel.pop         = 1'b1;
                sel.prefix_next = 1'b0;
            end else if (head[9:8] == 2'b01) begin
                sel.rsp         = PFX_KEYPAD;
                sel.prefix_next = 1'b1;
            end else if (head[9:8] == 2'b10) begin
                sel.rsp         = PFX_SHIFT;
                sel.prefix_next = 1'b1;
            end else begin
                sel.rsp = head[7:0];
                sel.pop = 1'b1;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/kbd_event_fifo.sv
// rtl/kbd_event_fifo.sv - Synchronous key-event FIFO with flush and drop indication
module kbd_event_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 10
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     dropped
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    // A pop in the same cycle frees the slot, so a full FIFO still accepts that push.
    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != FULL_CNT) || do_pop);
    assign dropped = push && !do_push && !flush;
    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign level   = count;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mac_kbd_link.sv
// rtl/mac_kbd_link.sv - Mac Plus keyboard serial link emulator; KBDIF_STATUS_EN adds fifo_level/overflow ports
module mac_kbd_link
    import kbd_link_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned CLK_HALF    = 5280,
    parameter int unsigned INQ_TIMEOUT = 8000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       kbd_strobe,
    input  logic [9:0] kbd_data,
    output logic       link_clk,
    input  logic       link_data_in,
    output logic       link_data_out,
    output logic       link_data_oe
`ifdef KBDIF_STATUS_EN
    ,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        overflow
`endif
);

    localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;

    link_state_t   state;
    link_state_t   state_next;
    logic [31:0]   timer;
    logic          half_done;
    logic          inq_done;
    logic          host_start;
    logic [2:0]    bit_cnt;
    logic [7:0]    cmd_sh;
    logic [7:0]    rsp_sh;
    logic          prefix_pending;
    logic          strobe_prev;
    logic          strobe_primed;
    logic          din_low_q;
    logic          evt_push;
    logic          fifo_pop;
    logic          fifo_flush;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_dropped;
    logic [9:0]    fifo_head;
    logic [LW-1:0] level_int;
    logic          load_key;
    key_sel_t      key_sel;

    // The strobe history only becomes meaningful after one sample, so no push fires out of reset.
    assign evt_push   = strobe_primed && (kbd_strobe != strobe_prev);
    assign half_done  = (timer == CLK_HALF - 1);
    assign inq_done   = (timer == INQ_TIMEOUT - 1);
    assign host_start = (state == ST_IDLE) && !link_data_in && din_low_q;
    assign key_sel    = select_key(fifo_empty, prefix_pending, fifo_head);

    kbd_event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (10)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (evt_push),
        .push_data (kbd_data),
        .pop       (fifo_pop),
        .flush     (fifo_flush),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (level_int),
        .dropped   (fifo_dropped)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE:     if (host_start) state_next = ST_CMD_LO;
            ST_CMD_LO:   if (half_done) state_next = ST_CMD_HI;
            ST_CMD_HI:   if (half_done) state_next = (bit_cnt == 3'd7) ? ST_DECODE : ST_CMD_LO;
            ST_DECODE: begin
                case (cmd_sh)
                    CMD_INQUIRY:                     state_next = ST_INQ_WAIT;
                    CMD_INSTANT, CMD_MODEL, CMD_TEST: state_next = ST_RSP_PRE;
                    default:                         state_next = ST_IDLE;
                endcase
            end
            // A key that lands on the timeout cycle is still picked up by select_key.
            ST_INQ_WAIT: if (!fifo_empty || prefix_pending || inq_done) state_next = ST_RSP_PRE;
            ST_RSP_PRE:  if (half_done) state_next = ST_RSP_LO;
            ST_RSP_LO:   if (half_done) state_next = ST_RSP_HI;
            ST_RSP_HI:   if (half_done) state_next = (bit_cnt == 3'd7) ? ST_IDLE : ST_RSP_LO;
            default:     state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        link_clk      = !((state == ST_CMD_LO) || (state == ST_RSP_LO));
        link_data_oe  = (state == ST_RSP_PRE) || (state == ST_RSP_LO) || (state == ST_RSP_HI);
        link_data_out = ((state == ST_RSP_LO) || (state == ST_RSP_HI)) ? rsp_sh[7] : 1'b1;
        load_key      = ((state == ST_DECODE) && (cmd_sh == CMD_INSTANT)) ||
                        ((state == ST_INQ_WAIT) && (state_next == ST_RSP_PRE));
        fifo_pop      = load_key && key_sel.pop;
        fifo_flush    = (state == ST_DECODE) && (cmd_sh == CMD_MODEL);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer          <= '0;
            bit_cnt        <= '0;
            cmd_sh         <= '0;
            rsp_sh         <= 8'hFF;
            prefix_pending <= 1'b0;
            strobe_prev    <= 1'b0;
            strobe_primed  <= 1'b0;
            din_low_q      <= 1'b0;
        end else begin
            strobe_prev   <= kbd_strobe;
            strobe_primed <= 1'b1;
            din_low_q     <= (state == ST_IDLE) && !link_data_in;
            timer         <= (state_next != state) ? 32'd0 : timer + 32'd1;

            if (state == ST_IDLE) begin
                bit_cnt <= '0;
            end else if (((state == ST_CMD_HI) || (state == ST_RSP_HI)) && half_done) begin
                bit_cnt <= bit_cnt + 3'd1;
            end

            if ((state == ST_CMD_HI) && (timer == 32'd0)) begin
                cmd_sh <= {cmd_sh[6:0], link_data_in};
            end

            if (load_key) begin
                rsp_sh         <= key_sel.rsp;
                prefix_pending <= key_sel.prefix_next;
            end else if (fifo_flush) begin
                rsp_sh         <= RSP_MODEL;
                prefix_pending <= 1'b0;
            end else if ((state == ST_DECODE) && (cmd_sh == CMD_TEST)) begin
                rsp_sh <= RSP_ACK;
            end else if ((state == ST_RSP_HI) && half_done) begin
                rsp_sh <= {rsp_sh[6:0], 1'b1};
            end
        end
    end

`ifdef KBDIF_STATUS_EN
    logic status_unused;
    assign status_unused = fifo_full;
    assign fifo_level    = level_int;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (fifo_flush) begin
            overflow <= 1'b0;
        end else if (fifo_dropped) begin
            overflow <= 1'b1;
        end
    end
`else
    logic status_unused;
    assign status_unused = ^{fifo_full, level_int, fifo_dropped};
`endif

endmodule

// File: tb/tb_mac_kbd_link.sv
// tb/tb_mac_kbd_link.sv - Scoreboard bench for mac_kbd_link with a queue-based keyboard model
module tb_mac_kbd_link;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned CH    = 4;
    localparam int unsigned ITO   = 200;

    logic       clk = 1'b0;
    logic       reset;
    logic       kbd_strobe;
    logic [9:0] kbd_data;
    logic       link_clk;
    logic       link_data_in;
    logic       link_data_out;
    logic       link_data_oe;
`ifdef KBDIF_STATUS_EN
    logic [3:0] fifo_level;
    logic       overflow;
`endif

    always #5 clk = ~clk;

    mac_kbd_link #(
        .FIFO_DEPTH  (DEPTH),
        .CLK_HALF    (CH),
        .INQ_TIMEOUT (ITO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .kbd_strobe    (kbd_strobe),
        .kbd_data      (kbd_data),
        .link_clk      (link_clk),
        .link_data_in  (link_data_in),
        .link_data_out (link_data_out),
        .link_data_oe  (link_data_oe)
`ifdef KBDIF_STATUS_EN
        ,
        .fifo_level    (fifo_level),
        .overflow      (overflow)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: the keyboard's pending events as a plain queue
    logic [9:0] m_q[$];
    bit         m_pfx = 0;
    bit         m_ovf = 0;
    logic [7:0] exp_q[$];
    int         issued = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void m_reset();
        m_q.delete();
        m_pfx = 0;
        m_ovf = 0;
    endfunction

    function automatic void m_push(input logic [9:0] e);
        if (m_q.size() < DEPTH) m_q.push_back(e);
        else m_ovf = 1;
    endfunction

    function automatic logic [7:0] m_key();
        logic [9:0] h;
        if (m_q.size() == 0) return 8'h7B;
        h = m_q[0];
        if (m_pfx) begin
            m_pfx = 0;
            m_q.delete(0);
            return h[7:0];
        end
        if (h[9:8] == 2'b01) begin m_pfx = 1; return 8'h79; end
        if (h[9:8] == 2'b10) begin m_pfx = 1; return 8'h71; end
        m_q.delete(0);
        return h[7:0];
    endfunction

    function automatic bit m_cmd(input logic [7:0] c);
        case (c)
            8'h10, 8'h14: exp_q.push_back(m_key());
            8'h16: begin m_q.delete(); m_pfx = 0; m_ovf = 0; exp_q.push_back(8'h0B); end
            8'h36: exp_q.push_back(8'h7D);
            default: return 0;
        endcase
        return 1;
    endfunction

    // Monitor: watches link_clk edges, assembles response bytes and checks them against the scoreboard
    logic [7:0] mon_sh = 8'h00;
    int nb = 0;
    int rsp_seen = 0;
    int last_cmd_rise = 0;
    int rsp_start = 0;
    int clk_falls = 0;
    logic lc_prev = 1'b1;

    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                nb = 0;
                lc_prev = 1'b1;
            end else begin
                if (lc_prev && !link_clk) begin
                    clk_falls++;
                    if (link_data_oe && nb == 0) rsp_start = cyc;
                end
                if (!lc_prev && link_clk) begin
                    if (link_data_oe) begin
                        mon_sh = {mon_sh[6:0], link_data_out};
                        nb++;
                        if (nb == 8) begin
                            nb = 0;
                            rsp_seen++;
                            if (exp_q.size() == 0) begin
                                n_cmp++;
                                n_bad++;
                                $display("FAIL rsp_unexpected: got %0h expected none", mon_sh);
                            end else begin
                                check("rsp_byte", {24'd0, mon_sh}, {24'd0, exp_q.pop_front()});
                            end
                        end
                    end else begin
                        last_cmd_rise = cyc;
                    end
                end
                lc_prev = link_clk;
            end
        end
    end

    int evt_cyc = 0;

    task automatic drive_evt(input logic [9:0] e);
        @(negedge clk);
        kbd_data   = e;
        kbd_strobe = ~kbd_strobe;
        evt_cyc    = cyc;
        @(negedge clk);
    endtask

    task automatic push_evt(input logic [9:0] e);
        m_push(e);
        drive_evt(e);
    endtask

    task automatic wait_edge(input bit want_rise, output bit ok);
        logic prev;
        ok = 0;
        prev = link_clk;
        for (int i = 0; i < 8 * CH + 20; i++) begin
            @(negedge clk);
            if (want_rise ? (!prev && link_clk) : (prev && !link_clk)) begin
                ok = 1;
                break;
            end
            prev = link_clk;
        end
    endtask

    task automatic host_send(input logic [7:0] c);
        bit ok;
        @(negedge clk);
        link_data_in = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            wait_edge(1'b0, ok);
            if (!ok) begin
                n_cmp++;
                n_bad++;
                $display("FAIL cmd_clock: no link_clk fall for bit %0d of cmd %0h", i, c);
                link_data_in = 1'b1;
                return;
            end
            link_data_in = c[i];
        end
        wait_edge(1'b1, ok);
        repeat (2) @(negedge clk);
        link_data_in = 1'b1;
    endtask

    task automatic wait_rsp(input int target);
        for (int i = 0; i < int'(ITO + 40 * CH + 100) && rsp_seen < target; i++) @(negedge clk);
        check("rsp_done", (rsp_seen >= target) ? 32'd1 : 32'd0, 32'd1);
        repeat (CH + 2) @(negedge clk);
    endtask

    task automatic send_cmd(input logic [7:0] c);
        bit has_rsp;
        has_rsp = m_cmd(c);
        if (has_rsp) issued++;
        host_send(c);
        if (has_rsp) wait_rsp(issued);
    endtask

    logic [7:0] rnd_cmds [5] = '{8'h14, 8'h14, 8'h10, 8'h16, 8'h36};

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit   ok;
        int   base;
        reset        = 1'b1;
        kbd_strobe   = 1'b1;
        kbd_data     = '0;
        link_data_in = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_link_clk", {31'd0, link_clk}, 32'd1);
        check("reset_data_out", {31'd0, link_data_out}, 32'd1);
        check("reset_data_oe", {31'd0, link_data_oe}, 32'd0);
`ifdef KBDIF_STATUS_EN
        check("reset_level", {28'd0, fifo_level}, 32'd0);
        check("reset_overflow", {31'd0, overflow}, 32'd0);
`endif
        reset = 1'b0;
        m_reset();
        repeat (3) @(negedge clk);

        // Strobe high across reset must not create an event
        send_cmd(8'h14);

        push_evt(10'h02A);
        send_cmd(8'h14);
        check("instant_latency", rsp_start - last_cmd_rise, 2 * CH + 1);
`ifdef KBDIF_STATUS_EN
        check("level_after_instant", {28'd0, fifo_level}, 32'd0);
`endif

        send_cmd(8'h10);
        check("inquiry_timeout", rsp_start - last_cmd_rise, 2 * CH + 1 + ITO);

        m_push(10'h05C);
        if (m_cmd(8'h10)) issued++;
        host_send(8'h10);
        repeat (50) @(negedge clk);
        drive_evt(10'h05C);
        wait_rsp(issued);
        check("inquiry_early", rsp_start - evt_cyc, CH + 2);

        push_evt(10'h10D);
        send_cmd(8'h14);
        send_cmd(8'h14);
        send_cmd(8'h14);

        for (int i = 0; i < 10; i++) push_evt(10'(i + 1));
`ifdef KBDIF_STATUS_EN
        check("overflow_set", {31'd0, overflow}, {31'd0, m_ovf});
        check("level_full", {28'd0, fifo_level}, DEPTH);
`endif
        for (int i = 0; i < 9; i++) send_cmd(8'h14);

        push_evt(10'h011);
        push_evt(10'h212);
        push_evt(10'h013);
        send_cmd(8'h16);
`ifdef KBDIF_STATUS_EN
        check("overflow_clr", {31'd0, overflow}, 32'd0);
`endif
        send_cmd(8'h14);
        send_cmd(8'h36);

        host_send(8'h55);
        base = clk_falls;
        repeat (6 * CH + 20) @(negedge clk);
        check("unknown_no_clock", clk_falls - base, 32'd0);

        for (int it = 0; it < 30; it++) begin
            int n;
            n = $urandom_range(0, 3);
            for (int k = 0; k < n; k++) push_evt(10'($urandom_range(0, 1023)));
            send_cmd(rnd_cmds[$urandom_range(0, 4)]);
        end

        push_evt(10'h033);
        host_send(8'h14);
        ok = 0;
        for (int i = 0; i < int'(20 * CH + 50); i++) begin
            @(negedge clk);
            if (nb == 4) begin ok = 1; break; end
        end
        check("reach_bit4", {31'd0, ok}, 32'd1);
        reset = 1'b1;
        #1;
        check("abort_link_clk", {31'd0, link_clk}, 32'd1);
        check("abort_data_oe", {31'd0, link_data_oe}, 32'd0);
        m_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        send_cmd(8'h36);
        send_cmd(8'h14);

        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
